// File: rtl/pkt_out_framer.sv
// Output packet framer: wraps the capture-memory sample stream into
// header / data / idle-filler / gap packets for the ADC_DATA pads.
module pkt_out_framer #(
  parameter int DW     = 18,
  parameter int GAP_W  = 8,
  parameter int IDLE_W = 4,
  parameter int SEQ_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_en,
  input  logic              i_seq_clr,
  input  logic [1:0]        i_cfg_data_length,
  input  logic [IDLE_W-1:0] i_cfg_idle_length,
  input  logic [GAP_W-1:0]  i_cfg_gap,
  input  logic [DW-1:0]     i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic [DW-1:0]     o_adc_data,
  output logic              o_adc_data_valid,
  output logic              o_pkt_busy,
  output logic              o_pkt_done,
  output logic [SEQ_W-1:0]  o_pkt_seq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_TAIL,
    S_GAP
  } state_t;

  localparam logic [10:0]       WCNT_ONE = 11'd1;
  localparam logic [IDLE_W-1:0] IDLE_ONE = {{(IDLE_W-1){1'b0}}, 1'b1};
  localparam logic [GAP_W-1:0]  GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};
  localparam logic [SEQ_W-1:0]  SEQ_ONE  = {{(SEQ_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [1:0]        r_len;
  logic [IDLE_W-1:0] r_idle;
  logic [GAP_W-1:0]  r_gap;
  logic [10:0]       r_word_cnt;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [SEQ_W-1:0]  r_seq;
  logic [DW-1:0]     r_adc_data;
  logic              r_adc_valid;
  logic              r_pkt_done;

  state_t            w_next_state;
  state_t            w_end_state;
  logic [DW-1:0]     w_adc_data;
  logic              w_adc_valid;
  logic              w_pkt_done;
  logic [10:0]       w_word_cnt;
  logic [IDLE_W-1:0] w_idle_cnt;
  logic [GAP_W-1:0]  w_gap_cnt;
  logic [10:0]       w_num_words;
  logic [DW-1:0]     w_header;
  logic              w_xfer;
  logic              w_last_word;

  always_comb begin
    w_num_words = 11'd216;
    case (r_len)
      2'b00:   w_num_words = 11'd216;
      2'b01:   w_num_words = 11'd432;
      2'b10:   w_num_words = 11'd864;
      default: w_num_words = 11'd1728;
    endcase
  end

  always_comb begin
    w_header                 = '0;
    w_header[SEQ_W-1:0]      = r_seq;
    w_header[DW-1:DW-2]      = 2'b11;
  end

  assign w_xfer      = i_in_valid && (r_state == S_DATA);
  assign w_last_word = (r_word_cnt == (w_num_words - WCNT_ONE));
  // Packets end in HDR for back-to-back framing, or IDLE once enable drops.
  assign w_end_state = i_en ? S_HDR : S_IDLE;

  always_comb begin
    w_next_state = r_state;
    w_adc_data   = '0;
    w_adc_valid  = 1'b0;
    w_pkt_done   = 1'b0;
    w_word_cnt   = r_word_cnt;
    w_idle_cnt   = r_idle_cnt;
    w_gap_cnt    = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_en) begin
          w_next_state = S_HDR;
        end
      end
      S_HDR: begin
        w_adc_data   = w_header;
        w_adc_valid  = 1'b1;
        w_word_cnt   = '0;
        w_idle_cnt   = '0;
        w_gap_cnt    = '0;
        w_next_state = S_DATA;
      end
      S_DATA: begin
        if (w_xfer) begin
          w_adc_data  = i_in_data;
          w_adc_valid = 1'b1;
          if (w_last_word) begin
            w_word_cnt = '0;
            w_pkt_done = (r_idle == '0);
            if (r_idle != '0) begin
              w_next_state = S_TAIL;
            end else if (r_gap != '0) begin
              w_next_state = S_GAP;
            end else begin
              w_next_state = w_end_state;
            end
          end else begin
            w_word_cnt = r_word_cnt + WCNT_ONE;
          end
        end else begin
          // Stalled upstream: the pad keeps its last word with valid low.
          w_adc_data = r_adc_data;
        end
      end
      S_TAIL: begin
        w_adc_valid = 1'b1;
        if (r_idle_cnt == (r_idle - IDLE_ONE)) begin
          w_pkt_done = 1'b1;
          w_idle_cnt = '0;
          if (r_gap != '0) begin
            w_next_state = S_GAP;
          end else begin
            w_next_state = w_end_state;
          end
        end else begin
          w_idle_cnt = r_idle_cnt + IDLE_ONE;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == (r_gap - GAP_ONE)) begin
          w_gap_cnt    = '0;
          w_next_state = w_end_state;
        end else begin
          w_gap_cnt = r_gap_cnt + GAP_ONE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_word_cnt  <= '0;
      r_idle_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_adc_data  <= '0;
      r_adc_valid <= 1'b0;
      r_pkt_done  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_word_cnt  <= w_word_cnt;
      r_idle_cnt  <= w_idle_cnt;
      r_gap_cnt   <= w_gap_cnt;
      r_adc_data  <= w_adc_data;
      r_adc_valid <= w_adc_valid;
      r_pkt_done  <= w_pkt_done;
    end
  end

  // Packet config is frozen at the header so mid-packet edits wait for the next one.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_len  <= '0;
      r_idle <= '0;
      r_gap  <= '0;
    end else if (r_state == S_HDR) begin
      r_len  <= i_cfg_data_length;
      r_idle <= i_cfg_idle_length;
      r_gap  <= i_cfg_gap;
    end
  end

  // Clear takes priority over the header increment; the header already carries the old value.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_seq <= '0;
    end else if (i_seq_clr) begin
      r_seq <= '0;
    end else if (r_state == S_HDR) begin
      r_seq <= r_seq + SEQ_ONE;
    end
  end

  assign o_in_ready       = (r_state == S_DATA);
  assign o_pkt_busy       = (r_state != S_IDLE);
  assign o_adc_data       = r_adc_data;
  assign o_adc_data_valid = r_adc_valid;
  assign o_pkt_done       = r_pkt_done;
  assign o_pkt_seq        = r_seq;

endmodule
